reg_scoreboard: RTL and testbench

Register scoreboard and issue controller for the 16-entry integer register file. Tracks in-flight writes per architectural register, including the special destination such as RDX for MUL/DIV. It stalls issue on read-after-write hazards or pending-counter overflow. It releases registers when the WriteBack stage retires an instruction. It sits between decode/issue and WriteBack, and its bitmap replaces the combinationally recomputed in-use map.

---
 rtl/reg_scoreboard_if.sv | 51 +++++
 rtl/reg_scoreboard.sv | 108 ++++++++++
 tb/tb_reg_scoreboard.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/reg_scoreboard_if.sv
// ============================================================================
// Module   : reg_scoreboard_if
// Brief    : Issue / writeback / status bundle between decode, WriteBack and
//            the register scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface reg_scoreboard_if #(
  parameter int NUM_REGS = 16
);
  localparam int REG_W = $clog2(NUM_REGS);

  logic                 issueValidIn;
  logic [REG_W-1:0]     sourceReg1In;
  logic [REG_W-1:0]     sourceReg2In;
  logic                 sourceReg1ValidIn;
  logic                 sourceReg2ValidIn;
  logic [REG_W-1:0]     destRegIn;
  logic                 destRegValidIn;
  logic [REG_W-1:0]     destRegSpecialIn;
  logic                 destRegSpecialValidIn;
  logic                 issueReadyOut;
  logic                 wbValidIn;
  logic [REG_W-1:0]     wbDestRegIn;
  logic [REG_W-1:0]     wbDestRegSpecialIn;
  logic                 wbDestRegValidIn;
  logic                 wbDestRegSpecialValidIn;
  logic                 flushIn;
  logic [NUM_REGS-1:0]  regInUseBitMapOut;
  logic [15:0]          stallCountOut;
  logic                 underflowErrOut;

  modport master (
    output issueValidIn, sourceReg1In, sourceReg2In, sourceReg1ValidIn,
           sourceReg2ValidIn, destRegIn, destRegValidIn, destRegSpecialIn,
           destRegSpecialValidIn, wbValidIn, wbDestRegIn, wbDestRegSpecialIn,
           wbDestRegValidIn, wbDestRegSpecialValidIn, flushIn,
    input  issueReadyOut, regInUseBitMapOut, stallCountOut, underflowErrOut
  );

  modport slave (
    input  issueValidIn, sourceReg1In, sourceReg2In, sourceReg1ValidIn,
           sourceReg2ValidIn, destRegIn, destRegValidIn, destRegSpecialIn,
           destRegSpecialValidIn, wbValidIn, wbDestRegIn, wbDestRegSpecialIn,
           wbDestRegValidIn, wbDestRegSpecialValidIn, flushIn,
    output issueReadyOut, regInUseBitMapOut, stallCountOut, underflowErrOut
  );
endinterface

`default_nettype wire

// File: rtl/reg_scoreboard.sv
// ============================================================================
// Module   : reg_scoreboard
// Brief    : Per-register pending-write counters gating issue on RAW hazards
//            and counter overflow; released in order by WriteBack.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_scoreboard #(
  parameter int NUM_REGS = 16,
  parameter int CNT_W    = 2
) (
  input  wire logic          clk,
  input  wire logic          resetN,
  reg_scoreboard_if.slave    bus
);

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [15:0]      STALL_MAX = 16'hFFFF;

  logic [CNT_W-1:0]    count_q [NUM_REGS];
  logic [CNT_W-1:0]    count_d [NUM_REGS];
  logic [NUM_REGS-1:0] bitmap_q, bitmap_d;
  logic [15:0]         stall_count_q, stall_count_d;
  logic                underflow_err_q, underflow_err_d;

  logic [NUM_REGS-1:0] iss_set;
  logic [NUM_REGS-1:0] rel_set;
  logic [NUM_REGS-1:0] inc_vec;
  logic                raw_hazard;
  logic                ovf_hazard;
  logic                issue_ready;
  logic                issue_fire;
  logic                any_underflow;

  // Hazard detection looks only at registered counts: no writeback bypass.
  always_comb begin
    iss_set = '0;
    rel_set = '0;
    if (bus.destRegValidIn)        iss_set[bus.destRegIn]        = 1'b1;
    if (bus.destRegSpecialValidIn) iss_set[bus.destRegSpecialIn] = 1'b1;
    if (bus.wbValidIn) begin
      if (bus.wbDestRegValidIn)        rel_set[bus.wbDestRegIn]        = 1'b1;
      if (bus.wbDestRegSpecialValidIn) rel_set[bus.wbDestRegSpecialIn] = 1'b1;
    end

    raw_hazard = (bus.sourceReg1ValidIn && (count_q[bus.sourceReg1In] != '0)) ||
                 (bus.sourceReg2ValidIn && (count_q[bus.sourceReg2In] != '0));

    ovf_hazard = 1'b0;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (iss_set[r] && (count_q[r] == CNT_MAX)) ovf_hazard = 1'b1;
    end

    issue_ready = resetN && !bus.flushIn && !raw_hazard && !ovf_hazard;
    issue_fire  = bus.issueValidIn && issue_ready;
    inc_vec     = iss_set & {NUM_REGS{issue_fire}};
  end

  always_comb begin
    any_underflow = 1'b0;
    for (int r = 0; r < NUM_REGS; r++) begin
      count_d[r] = count_q[r];
      case ({inc_vec[r], rel_set[r]})
        2'b10: count_d[r] = count_q[r] + CNT_ONE;
        2'b01: begin
          if (count_q[r] != '0) count_d[r] = count_q[r] - CNT_ONE;
          else                  any_underflow = 1'b1;
        end
        default: count_d[r] = count_q[r];
      endcase
      // A flush discards everything in flight, including this cycle's traffic.
      if (bus.flushIn) count_d[r] = '0;
      bitmap_d[r] = (count_d[r] != '0);
    end

    underflow_err_d = underflow_err_q | (any_underflow && !bus.flushIn);

    stall_count_d = stall_count_q;
    if (bus.issueValidIn && !issue_ready && !bus.flushIn &&
        (stall_count_q != STALL_MAX)) begin
      stall_count_d = stall_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      for (int r = 0; r < NUM_REGS; r++) count_q[r] <= '0;
      bitmap_q        <= '0;
      stall_count_q   <= '0;
      underflow_err_q <= 1'b0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) count_q[r] <= count_d[r];
      bitmap_q        <= bitmap_d;
      stall_count_q   <= stall_count_d;
      underflow_err_q <= underflow_err_d;
    end
  end

  assign bus.issueReadyOut     = issue_ready;
  assign bus.regInUseBitMapOut = bitmap_q;
  assign bus.stallCountOut     = stall_count_q;
  assign bus.underflowErrOut   = underflow_err_q;

endmodule

`default_nettype wire

// File: tb/tb_reg_scoreboard.sv
// ============================================================================
// Module   : tb_reg_scoreboard
// Brief    : Directed table-driven bench for reg_scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reg_scoreboard;

  localparam int N = 16;  // code >= 16 means "valid bit clear", code = x[3:0]

  logic clk;
  logic resetN;

  reg_scoreboard_if #(.NUM_REGS(16)) bus ();

  reg_scoreboard #(.NUM_REGS(16), .CNT_W(2)) dut (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n, iv, fl, wv;
    int          s1, s2, d, ds, wd, wds;
    logic        erdy;
    logic [15:0] emap;
    logic [15:0] est;
    logic        eue;
  } vec_t;

  int total = 0;
  int bad   = 0;

  function automatic vec_t mk(input logic rst_n, input logic iv,
                              input int s1, input int s2, input int d, input int ds,
                              input logic wv, input int wd, input int wds,
                              input logic fl, input logic erdy,
                              input int emap, input int est, input logic eue);
    vec_t v;
    v.rst_n = rst_n; v.iv = iv; v.s1 = s1; v.s2 = s2; v.d = d; v.ds = ds;
    v.wv = wv; v.wd = wd; v.wds = wds; v.fl = fl; v.erdy = erdy;
    v.emap = 16'(emap); v.est = 16'(est); v.eue = eue;
    return v;
  endfunction

  task automatic chk(input string name, input int idx,
                     input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    resetN                      = v.rst_n;
    bus.issueValidIn            = v.iv;
    bus.sourceReg1ValidIn       = (v.s1 < 16);
    bus.sourceReg1In            = 4'(v.s1);
    bus.sourceReg2ValidIn       = (v.s2 < 16);
    bus.sourceReg2In            = 4'(v.s2);
    bus.destRegValidIn          = (v.d < 16);
    bus.destRegIn               = 4'(v.d);
    bus.destRegSpecialValidIn   = (v.ds < 16);
    bus.destRegSpecialIn        = 4'(v.ds);
    bus.wbValidIn               = v.wv;
    bus.wbDestRegValidIn        = (v.wd < 16);
    bus.wbDestRegIn             = 4'(v.wd);
    bus.wbDestRegSpecialValidIn = (v.wds < 16);
    bus.wbDestRegSpecialIn      = 4'(v.wds);
    bus.flushIn                 = v.fl;
  endtask

  // Inputs change at posedge+1; ready is checked at posedge+2, state after the edge.
  task automatic apply(input vec_t v, input int idx);
    drive(v);
    #1;
    chk("ready", idx, 16'(bus.issueReadyOut), 16'(v.erdy));
    @(posedge clk);
    #1;
    chk("bitmap", idx, bus.regInUseBitMapOut, v.emap);
    chk("stall", idx, bus.stallCountOut, v.est);
    chk("uerr", idx, 16'(bus.underflowErrOut), 16'(v.eue));
  endtask

  vec_t tbl[$];

  initial begin
    drive(mk(0, 0, N, N, N, N, 0, N, N, 0, 0, 0, 0, 0));

    //        rst iv s1 s2 d   ds  wv wd  wds fl rdy map    st eue
    tbl.push_back(mk(0, 0, N, N, N,  N,  0, N,  N,  0, 0, 'h0000, 0, 0));
    tbl.push_back(mk(0, 1, N, N, 3,  N,  0, N,  N,  0, 0, 'h0000, 0, 0));
    tbl.push_back(mk(1, 0, N, N, N,  N,  0, N,  N,  0, 1, 'h0000, 0, 0));
    // RAW on r3, released by writeback; no bypass in the writeback cycle
    tbl.push_back(mk(1, 1, N, N, 3,  N,  0, N,  N,  0, 1, 'h0008, 0, 0));
    tbl.push_back(mk(1, 1, 3, N, N,  N,  0, N,  N,  0, 0, 'h0008, 1, 0));
    tbl.push_back(mk(1, 1, 3, N, N,  N,  0, N,  N,  0, 0, 'h0008, 2, 0));
    tbl.push_back(mk(1, 1, 3, N, N,  N,  1, 3,  N,  0, 0, 'h0000, 3, 0));
    tbl.push_back(mk(1, 1, 3, N, N,  N,  0, N,  N,  0, 1, 'h0000, 3, 0));
    // Counter overflow on r5
    tbl.push_back(mk(1, 1, N, N, 5,  N,  0, N,  N,  0, 1, 'h0020, 3, 0));
    tbl.push_back(mk(1, 1, N, N, 5,  N,  0, N,  N,  0, 1, 'h0020, 3, 0));
    tbl.push_back(mk(1, 1, N, N, 5,  N,  0, N,  N,  0, 1, 'h0020, 3, 0));
    tbl.push_back(mk(1, 1, N, N, 5,  N,  0, N,  N,  0, 0, 'h0020, 4, 0));
    tbl.push_back(mk(1, 1, N, N, 5,  N,  1, 5,  N,  0, 0, 'h0020, 5, 0));
    tbl.push_back(mk(1, 1, N, N, 5,  N,  0, N,  N,  0, 1, 'h0020, 5, 0));
    tbl.push_back(mk(1, 0, N, N, N,  N,  1, 5,  N,  0, 1, 'h0020, 5, 0));
    tbl.push_back(mk(1, 0, N, N, N,  N,  1, 5,  N,  0, 1, 'h0020, 5, 0));
    tbl.push_back(mk(1, 0, N, N, N,  N,  1, 5,  N,  0, 1, 'h0000, 5, 0));
    // MUL-style dual destination, and equal codes counting once
    tbl.push_back(mk(1, 1, N, N, 0,  2,  0, N,  N,  0, 1, 'h0005, 5, 0));
    tbl.push_back(mk(1, 0, N, N, N,  N,  1, 0,  2,  0, 1, 'h0000, 5, 0));
    tbl.push_back(mk(1, 1, N, N, 7,  7,  0, N,  N,  0, 1, 'h0080, 5, 0));
    tbl.push_back(mk(1, 0, N, N, N,  N,  0, 7,  7,  0, 1, 'h0080, 5, 0));
    tbl.push_back(mk(1, 0, N, N, N,  N,  1, 7,  N,  0, 1, 'h0000, 5, 0));
    // Special-only destination (primary code 9 with valid clear)
    tbl.push_back(mk(1, 1, N, N, 25, 4,  0, N,  N,  0, 1, 'h0010, 5, 0));
    // Simultaneous inc/dec on r4, then release
    tbl.push_back(mk(1, 1, N, N, 4,  N,  1, 4,  N,  0, 1, 'h0010, 5, 0));
    tbl.push_back(mk(1, 0, N, N, N,  N,  1, 4,  N,  0, 1, 'h0000, 5, 0));
    // Inc/dec on a zero count: no underflow
    tbl.push_back(mk(1, 1, N, N, 10, N,  1, 10, N,  0, 1, 'h0000, 5, 0));
    // Counts {1:2, 9:1}, then flush with a colliding issue and writeback
    tbl.push_back(mk(1, 1, N, N, 1,  9,  0, N,  N,  0, 1, 'h0202, 5, 0));
    tbl.push_back(mk(1, 1, N, N, 1,  N,  0, N,  N,  0, 1, 'h0202, 5, 0));
    tbl.push_back(mk(1, 1, N, N, 6,  N,  1, 1,  N,  1, 0, 'h0000, 5, 0));
    tbl.push_back(mk(1, 1, 1, N, N,  N,  0, N,  N,  0, 1, 'h0000, 5, 0));
    tbl.push_back(mk(1, 0, N, N, N,  N,  1, 9,  N,  0, 1, 'h0000, 5, 1));
    // Source 2 hazard, then the same codes with valid bits clear
    tbl.push_back(mk(1, 1, N, N, 2,  N,  0, N,  N,  0, 1, 'h0004, 5, 1));
    tbl.push_back(mk(1, 1, N, 2, N,  N,  0, N,  N,  0, 0, 'h0004, 6, 1));
    tbl.push_back(mk(1, 1, 18, 18, N, N, 0, N,  N,  0, 1, 'h0004, 6, 1));
    // Reset mid-operation discards r2; a later release underflows
    tbl.push_back(mk(0, 0, N, N, N,  N,  0, N,  N,  0, 0, 'h0000, 0, 0));
    tbl.push_back(mk(1, 0, N, N, N,  N,  1, 2,  N,  0, 1, 'h0000, 0, 1));

    @(posedge clk);
    #1;
    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

    // Multi-cycle: consumer of r8 waits for a writeback two cycles in.
    begin
      int got;
      vec_t v;
      apply(mk(0, 0, N, N, N, N, 0, N, N, 0, 0, 'h0000, 0, 0), 100);
      apply(mk(1, 1, N, N, 8, N, 0, N, N, 0, 1, 'h0100, 0, 0), 101);
      got = -1;
      for (int c = 0; c < 10; c++) begin
        v = mk(1, 1, 8, N, N, N, (c == 2), 8, N, 0, 0, 0, 0, 0);
        drive(v);
        #1;
        if (bus.issueReadyOut) begin
          got = c;
          break;
        end
        @(posedge clk);
        #1;
      end
      chk("wake_cycle", 102, 16'(got), 16'd3);
      @(posedge clk);
      #1;
      chk("wake_stall", 103, bus.stallCountOut, 16'd3);
      chk("wake_map", 104, bus.regInUseBitMapOut, 16'h0000);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
